approx_mul_bist: RTL and testbench

//  On-chip built-in self-test for an 8x8 approximate multiplier (ERCM8-style: a, b, mask in; 16-bit product out).

---
 rtl/approx_mul_bist.sv | 153 +++++++++++++++
 tb/tb_approx_mul_bist.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_bist.sv
// Built-in self-test for an 8x8 approximate multiplier: drives LFSR operands,
// captures the product after a settle window and accumulates |ED| metrics.
module approx_mul_bist #(
    parameter logic [15:0] N_SAMPLES = 16'd10000,
    parameter int unsigned SETTLE    = 4,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  mask_cfg,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    output logic [6:0]  mul_mask,
    input  logic [15:0] mul_p,
    output logic        busy,
    output logic        done,
    output logic [15:0] sample_cnt,
    output logic [15:0] err_cnt,
    output logic [31:0] sum_aed,
    output logic [15:0] max_aed
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CAPT
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] settle_q, settle_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [6:0]  mask_q, mask_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] sample_q, sample_d;
    logic [15:0] err_q, err_d;
    logic [31:0] sum_q, sum_d;
    logic [15:0] max_q, max_d;

    logic [15:0] lfsr_next;
    logic [15:0] exact;
    logic [15:0] aed;

    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign exact     = {8'h00, a_q} * {8'h00, b_q};
    assign aed       = (exact >= mul_p) ? (exact - mul_p) : (mul_p - exact);

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        settle_d = settle_q;
        a_d      = a_q;
        b_d      = b_q;
        mask_d   = mask_q;
        busy_d   = busy_q;
        done_d   = done_q;
        sample_d = sample_q;
        err_d    = err_q;
        sum_d    = sum_q;
        max_d    = max_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sample_d = '0;
                    err_d    = '0;
                    sum_d    = '0;
                    max_d    = '0;
                    done_d   = 1'b0;
                    mask_d   = mask_cfg;
                    lfsr_d   = SEED;
                    busy_d   = 1'b1;
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                a_d      = lfsr_q[15:8];
                b_d      = lfsr_q[7:0];
                lfsr_d   = lfsr_next;
                settle_d = SETTLE_LAST;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (settle_q == '0) begin
                    state_d = S_CAPT;
                end else begin
                    settle_d = settle_q - 16'd1;
                end
            end
            S_CAPT: begin
                err_d    = err_q + {15'd0, (aed != '0)};
                sum_d    = sum_q + {16'd0, aed};
                if (aed > max_q) max_d = aed;
                sample_d = sample_q + 16'd1;
                if (sample_d == N_SAMPLES) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRIVE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lfsr_q   <= SEED;
            settle_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mask_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sample_q <= '0;
            err_q    <= '0;
            sum_q    <= '0;
            max_q    <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            settle_q <= settle_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mask_q   <= mask_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sample_q <= sample_d;
            err_q    <= err_d;
            sum_q    <= sum_d;
            max_q    <= max_d;
        end
    end

    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign mul_mask   = mask_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sample_cnt = sample_q;
    assign err_cnt    = err_q;
    assign sum_aed    = sum_q;
    assign max_aed    = max_q;

endmodule

// File: tb/tb_approx_mul_bist.sv
// Bench for approx_mul_bist: a stand-in multiplier with selectable error behaviour
// and a sample-by-sample arithmetic reference of the expected error metrics.
module tb_approx_mul_bist;

    localparam int N0   = 16;
    localparam int ST0  = 4;
    localparam int PER0 = ST0 + 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start0, busy0, done0;
    logic [6:0]  mask_cfg0, mul_mask0;
    logic [7:0]  mul_a0, mul_b0;
    logic [15:0] mul_p0, sample_cnt0, err_cnt0, max_aed0;
    logic [31:0] sum_aed0;

    logic        start1, busy1, done1;
    logic [6:0]  mask_cfg1, mul_mask1;
    logic [7:0]  mul_a1, mul_b1;
    logic [15:0] mul_p1, sample_cnt1, err_cnt1, max_aed1;
    logic [31:0] sum_aed1;

    int mode0;
    int errors = 0;
    int checks = 0;

    // 0 exact, 1 zero, 2 LSB flipped, 3 low bits truncated by mask
    function automatic logic [15:0] mul_model(input int mode, input logic [7:0] a,
                                              input logic [7:0] b, input logic [6:0] m);
        logic [15:0] ex;
        ex = 16'(int'(a) * int'(b));
        case (mode)
            0:       return ex;
            1:       return 16'h0000;
            2:       return ex ^ 16'h0001;
            default: return ex & ~{9'h000, m};
        endcase
    endfunction

    assign mul_p0 = mul_model(mode0, mul_a0, mul_b0, mul_mask0);
    assign mul_p1 = 16'h0000;

    approx_mul_bist #(.N_SAMPLES(16'd16), .SETTLE(ST0), .SEED(SEED)) u0 (
        .clk(clk), .rst(rst), .start(start0), .mask_cfg(mask_cfg0),
        .mul_a(mul_a0), .mul_b(mul_b0), .mul_mask(mul_mask0), .mul_p(mul_p0),
        .busy(busy0), .done(done0), .sample_cnt(sample_cnt0), .err_cnt(err_cnt0),
        .sum_aed(sum_aed0), .max_aed(max_aed0)
    );

    approx_mul_bist #(.N_SAMPLES(16'd1), .SETTLE(1), .SEED(SEED)) u1 (
        .clk(clk), .rst(rst), .start(start1), .mask_cfg(mask_cfg1),
        .mul_a(mul_a1), .mul_b(mul_b1), .mul_mask(mul_mask1), .mul_p(mul_p1),
        .busy(busy1), .done(done1), .sample_cnt(sample_cnt1), .err_cnt(err_cnt1),
        .sum_aed(sum_aed1), .max_aed(max_aed1)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int         mode;
        logic [6:0] mask;
        bit         disturb;
        int         e_err;
        longint     e_sum;
        int         e_max;
        int         e_a;
        int         e_b;
    } vec_t;

    // Walks the operand sequence sample by sample and accumulates |exact - product|.
    task automatic ref_run(input int mode, input logic [6:0] mask, input int n, output vec_t v);
        logic [15:0] lfsr;
        logic [7:0]  a, b;
        int          d;
        lfsr = SEED;
        v.mode = mode; v.mask = mask; v.disturb = 1'b0;
        v.e_err = 0; v.e_sum = 0; v.e_max = 0; v.e_a = 0; v.e_b = 0;
        for (int k = 0; k < n; k++) begin
            a = lfsr[15:8];
            b = lfsr[7:0];
            d = int'(a) * int'(b) - int'(mul_model(mode, a, b, mask));
            if (d < 0) d = -d;
            if (d != 0) v.e_err++;
            v.e_sum += d;
            if (d > v.e_max) v.e_max = d;
            v.e_a = int'(a);
            v.e_b = int'(b);
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    endtask

    task automatic run0(input logic [6:0] mask, input bit disturb, output int cycles);
        int mask_bad;
        mask_cfg0 = mask;
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        chk("done_clears_on_start", done0, 0);
        chk("busy_after_start", busy0, 1);
        cycles   = 0;
        mask_bad = 0;
        while (!done0 && cycles < PER0 * N0 + 50) begin
            if (disturb && cycles == 30) begin
                mask_cfg0 = ~mask;
                start0    = 1'b1;
            end
            if (disturb && cycles == 31) start0 = 1'b0;
            @(posedge clk); #1;
            cycles++;
            if (mul_mask0 !== mask) mask_bad++;
        end
        start0 = 1'b0;
        chk("mask_held_during_run", mask_bad, 0);
    endtask

    task automatic check_run(input vec_t v, input int cycles);
        chk("done_latency", cycles, PER0 * N0);
        chk("done_level", done0, 1);
        chk("busy_end", busy0, 0);
        chk("sample_cnt", sample_cnt0, N0);
        chk("err_cnt", err_cnt0, v.e_err);
        chk("sum_aed", sum_aed0, v.e_sum);
        chk("max_aed", max_aed0, v.e_max);
        chk("last_mul_a", mul_a0, v.e_a);
        chk("last_mul_b", mul_b0, v.e_b);
        chk("mul_mask", mul_mask0, v.mask);
    endtask

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cycles;
        vec_t v;

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        mask_cfg0 = 7'h00; mask_cfg1 = 7'h7F; mode0 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_sample_cnt", sample_cnt0, 0);
        chk("rst_err_cnt", err_cnt0, 0);
        chk("rst_sum_aed", sum_aed0, 0);
        chk("rst_max_aed", max_aed0, 0);
        chk("rst_mul_a", mul_a0, 0);
        chk("rst_mul_b", mul_b0, 0);
        chk("rst_mul_mask", mul_mask0, 0);
        rst = 1'b0;

        vecs[0] = '{0, 7'h00, 1'b0, 0, 0, 0, 0, 0};
        vecs[1] = '{2, 7'h13, 1'b0, N0, N0, 1, 0, 0};
        ref_run(1, 7'h00, N0, vecs[2]);
        ref_run(3, 7'h55, N0, vecs[3]);
        vecs[3].disturb = 1'b1;
        ref_run(3, 7'($urandom_range(1, 127)), N0, vecs[4]);
        ref_run(int'($urandom_range(0, 3)), 7'($urandom), N0, vecs[5]);
        // operand values for the constant rows come from the same walk
        ref_run(0, 7'h00, N0, v);
        vecs[0].e_a = v.e_a; vecs[0].e_b = v.e_b;
        vecs[1].e_a = v.e_a; vecs[1].e_b = v.e_b;

        for (int i = 0; i < 6; i++) begin
            mode0 = vecs[i].mode;
            run0(vecs[i].mask, vecs[i].disturb, cycles);
            check_run(vecs[i], cycles);
        end

        // reset in the middle of sample 3, then an uninterrupted rerun
        mode0 = 3;
        mask_cfg0 = 7'h21;
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        repeat (3 * PER0 + 2) @(posedge clk);
        #1;
        chk("pre_rst_sample_cnt", sample_cnt0, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrun_rst_busy", busy0, 0);
        chk("midrun_rst_done", done0, 0);
        chk("midrun_rst_sample_cnt", sample_cnt0, 0);
        chk("midrun_rst_sum_aed", sum_aed0, 0);
        chk("midrun_rst_mul_a", mul_a0, 0);
        chk("midrun_rst_mul_b", mul_b0, 0);
        chk("midrun_rst_mul_mask", mul_mask0, 0);
        rst = 1'b0;
        ref_run(3, 7'h21, N0, v);
        run0(7'h21, 1'b0, cycles);
        check_run(v, cycles);

        // single-sample run with the shortest settle window and a zero product
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        cycles = 0;
        while (!done1 && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk("n1_done_latency", cycles, 3);
        chk("n1_mul_a", mul_a1, 8'hAC);
        chk("n1_mul_b", mul_b1, 8'hE1);
        chk("n1_err_cnt", err_cnt1, 1);
        chk("n1_sum_aed", sum_aed1, 38700);
        chk("n1_max_aed", max_aed1, 38700);
        chk("n1_sample_cnt", sample_cnt1, 1);
        chk("n1_mul_mask", mul_mask1, 7'h7F);
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        chk("n1_restart_done_clear", done1, 0);
        chk("n1_restart_sample_clear", sample_cnt1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("n1_rerun_done", done1, 1);
        chk("n1_rerun_sum_aed", sum_aed1, 38700);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
